// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
// Imported by debounce_channel and btn_conditioner.
package btn_pkg;

    typedef enum logic {
        STABLE,
        COUNTING
    } db_state_t;

    localparam int DEF_DEBOUNCE_CYCLES    = 1_000_000;
    localparam int DEF_RST_STRETCH_CYCLES = 16;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchronizer, polarity fix, counter debouncer,
// and single-cycle press/release pulses aligned with the level change.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    db_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;

    logic          w_pressed;
    db_state_t     w_state;
    logic [CW-1:0] w_cnt;
    logic          w_level;
    logic          w_press;
    logic          w_release;

    assign w_pressed = r_sync2 ^ ACTIVE_LOW;

    // Two-flop synchronizer; resets to the unpressed pin level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce state, counter, level and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= STABLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_level   <= w_level;
            r_press   <= w_press;
            r_release <= w_release;
        end
    end

    // Next state: any return to the current level aborts the count.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_level   = r_level;
        w_press   = 1'b0;
        w_release = 1'b0;
        unique case (r_state)
            STABLE: begin
                if (w_pressed != r_level) begin
                    w_state = COUNTING;
                    w_cnt   = CW'(1);
                end
            end
            COUNTING: begin
                if (w_pressed == r_level) begin
                    w_state = STABLE;
                    w_cnt   = '0;
                end else if (r_cnt == LAST) begin
                    w_level   = ~r_level;
                    w_press   = ~r_level;
                    w_release = r_level;
                    w_state   = STABLE;
                    w_cnt     = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the board buttons and derives the stretched MicroBlaze reset
// from the system reset OR the debounced reset button.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN              = 4,
    parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW         = 1'b1,
    parameter int RST_BTN            = 0,
    parameter int RST_STRETCH_CYCLES = DEF_RST_STRETCH_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             mb_reset
);

    localparam int            SW    = $clog2(RST_STRETCH_CYCLES + 1);
    localparam logic [SW-1:0] SLAST = SW'(RST_STRETCH_CYCLES);

    logic [SW-1:0] r_scnt;
    logic          r_hold;
    logic [SW-1:0] w_scnt_inc;
    logic          w_cause;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .btn_raw    (btn_raw[g]),
            .btn_level  (btn_level[g]),
            .btn_press  (btn_press[g]),
            .btn_release(btn_release[g])
        );
    end

    assign w_cause    = reset | btn_level[RST_BTN];
    assign w_scnt_inc = r_scnt + 1'b1;

    // Stretch counter: held at zero while the cause lasts, then counts up
    // and saturates; r_hold covers the cycles after the cause ends.
    always_ff @(posedge clk) begin
        if (reset || btn_level[RST_BTN]) begin
            r_scnt <= '0;
            r_hold <= 1'b1;
        end else if (r_scnt != SLAST) begin
            r_scnt <= w_scnt_inc;
            r_hold <= (w_scnt_inc != SLAST);
        end
    end

    // Glitch-free OR of registered/synchronous terms.
    assign mb_reset = w_cause | r_hold;

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomized self-checking bench for btn_conditioner with a
// history-based behavioural model and hand-computed timing checks.
module tb_btn_conditioner;

    localparam int N = 4;
    localparam int D = 8;
    localparam int S = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic         mb_reset;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    btn_conditioner #(
        .N_BTN             (N),
        .DEBOUNCE_CYCLES   (D),
        .ACTIVE_LOW        (1'b1),
        .RST_BTN           (0),
        .RST_STRETCH_CYCLES(S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .mb_reset   (mb_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     nm, cyc, got, exp);
        end
    endtask

    // Behavioural model: a channel toggles once its last D synchronized
    // samples (since reset) all disagree with the current level.
    logic [N-1:0] m_s1    = '1;
    logic [N-1:0] m_s2    = '1;
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_press = '0;
    logic [N-1:0] m_rel   = '0;
    int           m_gap   = 1;
    bit           hist[N][$];

    always @(posedge clk) begin
        bit all;
        cyc++;
        if (reset || m_level[0]) m_gap = 1;
        else if (m_gap < 1000) m_gap++;
        if (reset) begin
            m_s1    = '1;
            m_s2    = '1;
            m_level = '0;
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < N; i++) hist[i].delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                m_press[i] = 1'b0;
                m_rel[i]   = 1'b0;
                hist[i].push_back(~m_s2[i]);
                if (hist[i].size() > D) void'(hist[i].pop_front());
                if (hist[i].size() == D) begin
                    all = 1'b1;
                    for (int j = 0; j < D; j++)
                        if (hist[i][j] == m_level[i]) all = 1'b0;
                    if (all) begin
                        m_level[i] = ~m_level[i];
                        if (m_level[i]) m_press[i] = 1'b1;
                        else m_rel[i] = 1'b1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    end

    // Event records for the literal timing checks.
    int   press_cyc[N];
    int   rel_cyc[N];
    int   press_n[N];
    int   rel_n[N];
    int   lvl0_rise = -1;
    int   lvl0_fall = -1;
    int   mb_rise   = -1;
    int   mb_fall   = -1;
    logic prev_mb   = 1'b1;
    logic prev_l0   = 1'b0;

    initial begin
        for (int i = 0; i < N; i++) begin
            press_cyc[i] = -1;
            rel_cyc[i]   = -1;
            press_n[i]   = 0;
            rel_n[i]     = 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic exp_mb;
        if (cyc >= 1) begin
            exp_mb = reset || m_level[0] || (m_gap <= S);
            chk("level", 32'(btn_level), 32'(m_level));
            chk("press", 32'(btn_press), 32'(m_press));
            chk("release", 32'(btn_release), 32'(m_rel));
            chk("mb_reset", 32'(mb_reset), 32'(exp_mb));
            chk("press_and_release", 32'(|(btn_press & btn_release)), 32'd0);
            for (int i = 0; i < N; i++) begin
                if (btn_press[i]) begin
                    press_cyc[i] = cyc;
                    press_n[i]++;
                end
                if (btn_release[i]) begin
                    rel_cyc[i] = cyc;
                    rel_n[i]++;
                end
            end
            if (btn_level[0] && !prev_l0) lvl0_rise = cyc;
            if (!btn_level[0] && prev_l0) lvl0_fall = cyc;
            if (mb_reset && !prev_mb) mb_rise = cyc;
            if (!mb_reset && prev_mb) mb_fall = cyc;
            prev_l0 = btn_level[0];
            prev_mb = mb_reset;
        end
    end

    task automatic drive(input logic r, input logic [N-1:0] raw, input int n);
        reset   = r;
        btn_raw = raw;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int t;
        int t1;
        int n0;
        int n1;
        reset   = 1'b1;
        btn_raw = 4'hF;
        repeat (3) @(posedge clk);
        #2;

        t = cyc;
        drive(1'b0, 4'hF, 12);
        chk("idle_level", 32'(btn_level), 32'd0);
        chk("idle_press_count", 32'(press_n[0] + press_n[1] + press_n[2] + press_n[3]), 32'd0);
        chk("reset_stretch_fall", 32'(mb_fall - t), 32'd4);

        t = cyc;
        drive(1'b0, 4'hB, 20);
        chk("press2_latency", 32'(press_cyc[2] - t), 32'd10);
        chk("press2_count", 32'(press_n[2]), 32'd1);
        t = cyc;
        drive(1'b0, 4'hF, 20);
        chk("release2_latency", 32'(rel_cyc[2] - t), 32'd10);
        chk("release2_count", 32'(rel_n[2]), 32'd1);

        n0 = press_n[1];
        n1 = rel_n[1];
        drive(1'b0, 4'hD, 5);
        drive(1'b0, 4'hF, 2);
        drive(1'b0, 4'hD, 5);
        drive(1'b0, 4'hF, 15);
        chk("glitch1_press", 32'(press_n[1] - n0), 32'd0);
        chk("glitch1_release", 32'(rel_n[1] - n1), 32'd0);

        t = cyc;
        drive(1'b0, 4'hE, 30);
        t1 = cyc;
        drive(1'b0, 4'hF, 20);
        chk("lvl0_rise", 32'(lvl0_rise - t), 32'd10);
        chk("mb_rise_with_lvl0", 32'(mb_rise - lvl0_rise), 32'd0);
        chk("lvl0_fall", 32'(lvl0_fall - t1), 32'd10);
        chk("mb_fall_after_lvl0", 32'(mb_fall - lvl0_fall), 32'd4);

        n0 = press_n[3];
        drive(1'b0, 4'h7, 6);
        drive(1'b1, 4'h7, 3);
        t = cyc;
        drive(1'b0, 4'h7, 14);
        chk("press3_after_reset", 32'(press_cyc[3] - t), 32'd10);
        chk("press3_count", 32'(press_n[3] - n0), 32'd1);
        drive(1'b0, 4'hF, 15);

        t = cyc;
        drive(1'b0, 4'h5, 15);
        chk("press1_simul", 32'(press_cyc[1] - t), 32'd10);
        chk("press3_simul", 32'(press_cyc[3] - t), 32'd10);
        drive(1'b0, 4'hF, 15);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 24) == 0)
                drive(1'b1, 4'($urandom), $urandom_range(1, 3));
            else
                drive(1'b0, 4'($urandom), $urandom_range(1, 14));
        end
        drive(1'b0, 4'hF, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
